multi_flexcounter: RTL
======================

// Module: multi_flexcounter
// PURPOSE
//  NUM_CH independent programmable counters sharing one prescaler; successor to the single-channel flex counter.
//  Each channel: up or down count, wrap or one-shot mode, 1-cycle terminal strobe, sticky done flag.
//  Drives bit/byte timing and timeout generation for controllers; count values readable every cycle.
// PARAMETERS
//  NUM_CH      4     number of counter channels
//  COUNTSIZE   1024  per-channel count range
//  COUNTWIDTH  $clog2(COUNTSIZE)  count/maxCount width
//  PRESCALE_W  8     prescaler divider width
// PORTS
//  clk            in   1                    clock, all logic rising-edge
//  RST            in   1                    synchronous reset, active-high
//  prescaleDiv    in   PRESCALE_W           tick every prescaleDiv+1 clk cycles
//  enableCounter  in   NUM_CH               per-channel advance enable
//  clear          in   NUM_CH               per-channel synchronous restart
//  mode           in   NUM_CH x cnt_mode_t  per-channel mode (2 bits)
//  maxCount       in   NUM_CH x COUNTWIDTH  per-channel terminal/reload value
//  count          out  NUM_CH x COUNTWIDTH  current count
//  strobe         out  NUM_CH               1-cycle terminal pulse
//  done           out  NUM_CH               sticky one-shot completion
//  tick           out  1                    prescaler tick (debug/observe)
// BEHAVIOUR
//  One clock (clk); reset synchronous, active-high (RST). RST wins over everything.
//  Reset: count=0, strobe=0, done=0, prescaler=0, tick=0 for all channels.
//  Prescaler: free-running, ignores enables/clear. pcnt>=prescaleDiv -> tick=1 that cycle, pcnt<=0;
//   else pcnt++. prescaleDiv=0 -> tick every cycle. Lowering prescaleDiv below pcnt: ticks next cycle (>=).
//  Advance(ch) = tick & enableCounter[ch] & ~clear[ch] & ~(oneshot & done[ch]).
//  Modes: WRAP_UP=0, WRAP_DOWN=1, ONESHOT_UP=2, ONESHOT_DOWN=3.
//  Terminal: up -> count>=maxCount; down -> count==0. Evaluated on current regs at advance.
//  Advance, not terminal: up count+1; down count-1.
//  Advance at terminal: strobe<=1 next cycle (exactly 1 cycle);
//   WRAP_UP count<=0; WRAP_DOWN count<=maxCount;
//   ONESHOT_*: count holds, done<=1 same edge as strobe; channel frozen until clear.
//  Strobe latency: 1 cycle after the terminal advance edge; visible with wrapped/held count.
//  clear[ch]: count<=0 (up modes) or maxCount (down modes); done<=0; strobe<=0. clear beats advance same cycle.
//  enableCounter low: count/done hold; strobe deasserts after its 1 cycle.
//  maxCount=0: every advance terminal; strobe every tick; count stays 0 (wrap modes).
//  maxCount changed mid-run: up uses new value next advance (>= covers count above it);
//   down picks new value only on wrap/clear.
//  mode changed mid-run: next advance uses new direction on current count; done unaffected until clear.
//  After reset a down channel sits at 0 (terminal): first advance strobes and loads maxCount.
//  Channels fully independent; simultaneous strobes on any subset allowed.
//  No arithmetic overflow: up never exceeds maxCount+... (wraps at >=); down never below 0.
// STRUCTURE
//  flexcounter_pkg: typedef enum logic [1:0] cnt_mode_t {WRAP_UP, WRAP_DOWN, ONESHOT_UP, ONESHOT_DOWN};
//   mode-decode helper functions is_down(), is_oneshot().
//  Sub-module flexcounter_channel (one channel: count/strobe/done regs), instantiated NUM_CH times in a
//   generate loop; prescaler lives in the top.
// TESTING
//  1 RST held 3 cycles with enables high -> count=0,strobe=0,done=0,tick=0 throughout; release, prescaleDiv=0.
//  2 ch0 WRAP_UP maxCount=3, prescaleDiv=0, enable -> count 1,2,3,0,1..; strobe high only cycle count shows 0.
//  3 ch1 ONESHOT_DOWN maxCount=5, prescaleDiv=2 -> reload 5 after first terminal, decrement every 3rd cycle
//    to 0, strobe 1 cycle, done=1 and count holds 0; clear -> count=5, done=0.
//  4 ch2 WRAP_UP count=7, maxCount rewritten to 4 -> next advance strobes, count=0; clear+enable same
//    cycle -> count=0, no strobe.
//  5 maxCount=0 all channels, prescaleDiv=1 -> strobe on every tick (every 2nd cycle), count stays 0.
//  6 RST asserted mid-run with done/strobe active -> all outputs 0 next cycle, prescaler restarts at 0.

Source files
------------

// File: rtl/flexcounter_pkg.sv
// -----------------------------------------------------------------------------
// flexcounter_pkg
//   Shared types and mode-decode helpers for the multi-channel flex counter.
//   cnt_mode_t encodes direction in bit 0 (1 = down) and one-shot in bit 1.
// -----------------------------------------------------------------------------
package flexcounter_pkg;

  typedef enum logic [1:0] {
    WRAP_UP      = 2'd0,
    WRAP_DOWN    = 2'd1,
    ONESHOT_UP   = 2'd2,
    ONESHOT_DOWN = 2'd3
  } cnt_mode_t;

  function automatic logic is_down(input cnt_mode_t m);
    return (m == WRAP_DOWN) || (m == ONESHOT_DOWN);
  endfunction

  function automatic logic is_oneshot(input cnt_mode_t m);
    return (m == ONESHOT_UP) || (m == ONESHOT_DOWN);
  endfunction

endpackage

// File: rtl/flexcounter_channel.sv
// -----------------------------------------------------------------------------
// flexcounter_channel
//   One programmable counter channel: up/down, wrap/one-shot, 1-cycle terminal
//   strobe and sticky done flag. Advances only on the shared prescaler tick.
// Ports
//   clk, RST    clock and synchronous active-high reset
//   tick        shared prescaler tick
//   enable      advance enable for this channel
//   clear       synchronous restart (beats advance)
//   mode        counting mode
//   max_count   terminal (up) / reload (down) value
//   count       current count
//   strobe      1-cycle pulse after a terminal advance
//   done        sticky one-shot completion flag
// -----------------------------------------------------------------------------
module flexcounter_channel
  import flexcounter_pkg::*;
#(
  parameter int COUNTWIDTH = 10
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  clear,
  input  cnt_mode_t             mode,
  input  logic [COUNTWIDTH-1:0] max_count,
  output logic [COUNTWIDTH-1:0] count,
  output logic                  strobe,
  output logic                  done
);

  logic [COUNTWIDTH-1:0] count_q, count_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  // Set by the first clear or advance after reset. A down channel leaves
  // reset parked at 0; that state is not a finished countdown, so its first
  // terminal advance reloads max_count instead of completing a one-shot.
  logic                  loaded_q, loaded_d;

  logic down, oneshot, advance, terminal;

  assign down     = is_down(mode);
  assign oneshot  = is_oneshot(mode);
  assign advance  = tick & enable & ~clear & ~(oneshot & done_q);
  // >= rather than == so a count left above a lowered max_count still wraps.
  assign terminal = down ? (count_q == '0) : (count_q >= max_count);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    strobe_d = 1'b0;
    done_d   = done_q;
    loaded_d = loaded_q;
    if (clear) begin
      count_d  = down ? max_count : '0;
      done_d   = 1'b0;
      loaded_d = 1'b1;
    end else if (advance) begin
      loaded_d = 1'b1;
      if (terminal) begin
        strobe_d = 1'b1;
        if (oneshot && (loaded_q || !down)) begin
          done_d = 1'b1;
        end else begin
          count_d = down ? max_count : '0;
        end
      end else begin
        count_d = down ? (count_q - COUNTWIDTH'(1)) : (count_q + COUNTWIDTH'(1));
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of process order.
  always_ff @(posedge clk) begin
    if (RST) begin
      count_q  <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
    end
  end

  assign count  = count_q;
  assign strobe = strobe_q;
  assign done   = done_q;

endmodule

// File: rtl/multi_flexcounter.sv
// -----------------------------------------------------------------------------
// multi_flexcounter
//   NUM_CH independent programmable counters sharing one free-running
//   prescaler. Used for bit/byte timing and timeouts in controllers.
// Ports
//   clk            clock, rising edge
//   RST            synchronous reset, active-high
//   prescaleDiv    tick every prescaleDiv+1 clk cycles
//   enableCounter  per-channel advance enable
//   clear          per-channel synchronous restart
//   mode           per-channel cnt_mode_t
//   maxCount       per-channel terminal/reload value
//   count          per-channel current count
//   strobe         per-channel 1-cycle terminal pulse
//   done           per-channel sticky one-shot completion
//   tick           prescaler tick, for observation
// -----------------------------------------------------------------------------
module multi_flexcounter
  import flexcounter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int COUNTSIZE  = 1024,
  parameter int COUNTWIDTH = $clog2(COUNTSIZE),
  parameter int PRESCALE_W = 8
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic [PRESCALE_W-1:0]            prescaleDiv,
  input  logic [NUM_CH-1:0]                enableCounter,
  input  logic [NUM_CH-1:0]                clear,
  input  cnt_mode_t [NUM_CH-1:0]           mode,
  input  logic [NUM_CH-1:0][COUNTWIDTH-1:0] maxCount,
  output logic [NUM_CH-1:0][COUNTWIDTH-1:0] count,
  output logic [NUM_CH-1:0]                strobe,
  output logic [NUM_CH-1:0]                done,
  output logic                             tick
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  pre_tick;

  // >= so that lowering prescaleDiv below the running count ticks at once
  // instead of waiting for the prescaler to wrap through its full range.
  assign pre_tick = (pcnt_q >= prescaleDiv);

  always_comb begin
    pcnt_d = pre_tick ? '0 : (pcnt_q + PRESCALE_W'(1));
  end

  always_ff @(posedge clk) begin
    if (RST) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  // Masked during reset so the observed tick reads 0 while RST is held.
  assign tick = pre_tick & ~RST;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    flexcounter_channel #(
      .COUNTWIDTH(COUNTWIDTH)
    ) u_ch (
      .clk      (clk),
      .RST      (RST),
      .tick     (tick),
      .enable   (enableCounter[g]),
      .clear    (clear[g]),
      .mode     (mode[g]),
      .max_count(maxCount[g]),
      .count    (count[g]),
      .strobe   (strobe[g]),
      .done     (done[g])
    );
  end

endmodule
